// File: rtl/skew_acc_pkg.sv
// skew_acc_pkg: shared token type and saturating add for the skewed accumulator array
package skew_acc_pkg;
    // Widest supported accumulator; sat_add works at this width and clamps to any narrower one
    localparam int ACC_W_MAX = 64;
    localparam int DEPTH_W_MAX = 8;

    typedef struct packed {
        logic                   valid;
        logic                   init;
        logic                   last;
        logic [DEPTH_W_MAX-1:0] depth;
    } acc_tok_t;

    typedef struct packed {
        logic [ACC_W_MAX-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    function automatic logic signed [ACC_W_MAX:0] acc_max(input int w);
        return (65'sd1 <<< (w - 1)) - 65'sd1;
    endfunction

    function automatic logic signed [ACC_W_MAX:0] acc_min(input int w);
        return -(65'sd1 <<< (w - 1));
    endfunction

    // Sum one bit wider than the operands, then clamp or wrap to the w-bit signed range
    function automatic sat_res_t sat_add(input logic signed [ACC_W_MAX-1:0] a, input logic signed [ACC_W_MAX-1:0] b, input int w, input logic sat_en);
        logic signed [ACC_W_MAX:0] s;
        logic signed [ACC_W_MAX:0] mx;
        logic signed [ACC_W_MAX:0] mn;
        sat_res_t r;
        s = a + b;
        mx = acc_max(w);
        mn = acc_min(w);
        r.ovf = (s > mx) || (s < mn);
        r.sum = (r.ovf && sat_en) ? ((s > mx) ? mx[ACC_W_MAX-1:0] : mn[ACC_W_MAX-1:0]) : s[ACC_W_MAX-1:0];
        return r;
    endfunction
endpackage

// File: rtl/skew_acc_lane.sv
// skew_acc_lane: one accumulator lane with token forwarding and its deskew delay chain
module skew_acc_lane
    import skew_acc_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int LANE_IDX   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  acc_tok_t             tok_i,
    output acc_tok_t             tok_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                 sat_en_i,
    output logic [ACC_WIDTH-1:0] res_o,
    output logic                 ovf_o,
    output logic                 vld_o
);
    // Capture stage plus SIZE-1-LANE_IDX deskew registers so every lane lands on the same edge
    localparam int DLY = SIZE - LANE_IDX;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_nx;
    logic signed [ACC_WIDTH-1:0]  base;
    logic signed [DATA_WIDTH-1:0] d;
    logic                         ovf;
    logic                         ovf_nx;
    logic                         act;
    sat_res_t                     r;
    logic [ACC_WIDTH+1:0]         cap;
    logic [ACC_WIDTH+1:0]         dly [DLY];

    // Accumulate or overwrite for active lanes; inactive lanes hold and capture zeros
    always_comb begin
        act    = tok_i.valid && (tok_i.depth > DEPTH_W_MAX'(LANE_IDX));
        base   = tok_i.init ? '0 : acc;
        d      = data_i;
        r      = sat_add(base, d, ACC_WIDTH, sat_en_i);
        acc_nx = act ? r.sum[ACC_WIDTH-1:0] : acc;
        ovf_nx = act ? ((!tok_i.init && ovf) || r.ovf) : ovf;
        cap    = {tok_i.valid && tok_i.last, act && ovf_nx, act ? acc_nx : '0};
    end

    // Token forwarding, accumulator state and deskew shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_o <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            for (int k = 0; k < DLY; k++) dly[k] <= '0;
        end else begin
            tok_o  <= tok_i;
            acc    <= acc_nx;
            ovf    <= ovf_nx;
            dly[0] <= cap;
            for (int k = 1; k < DLY; k++) dly[k] <= dly[k-1];
        end
    end

    assign {vld_o, ovf_o, res_o} = dly[DLY-1];
endmodule

// File: rtl/skew_acc_array.sv
// skew_acc_array: accumulates skewed PE partial-sum lanes and emits one aligned result beat per tile
module skew_acc_array
    import skew_acc_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int DEPTH_W    = $clog2(SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SIZE*DATA_WIDTH-1:0] data_i,
    input  logic                      valid_i,
    input  logic                      init_i,
    input  logic                      last_i,
    input  logic [DEPTH_W-1:0]        valid_depth_i,
    input  logic                      sat_en_i,
    output logic [SIZE*ACC_WIDTH-1:0] data_o,
    output logic                      out_valid_o,
    output logic [SIZE-1:0]           ovf_o,
    output logic                      tile_done_o
);
    acc_tok_t                  tok [SIZE+1];
    logic [SIZE*ACC_WIDTH-1:0] res;
    logic [SIZE-1:0]           ovf;
    logic [SIZE-1:0]           vld;

    assign tok[0] = '{valid: valid_i, init: init_i, last: last_i, depth: DEPTH_W_MAX'(valid_depth_i)};

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        skew_acc_lane #(
            .SIZE      (SIZE),
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .LANE_IDX  (g)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .tok_i   (tok[g]),
            .tok_o   (tok[g+1]),
            .data_i  (data_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .sat_en_i(sat_en_i),
            .res_o   (res[g*ACC_WIDTH +: ACC_WIDTH]),
            .ovf_o   (ovf[g]),
            .vld_o   (vld[g])
        );
    end

    // Register the aligned beat and flag the cycle after a burst ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= '0;
            ovf_o       <= '0;
            out_valid_o <= 1'b0;
            tile_done_o <= 1'b0;
        end else begin
            data_o      <= res;
            ovf_o       <= ovf;
            out_valid_o <= &vld;
            tile_done_o <= out_valid_o && !(&vld);
        end
    end
endmodule

// File: tb/tb_skew_acc_array.sv
// tb_skew_acc_array: directed checks of the skewed accumulator array at SIZE=4, 8-bit lanes
module tb_skew_acc_array;
    localparam int SIZE = 4;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int DEPW = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [SIZE*DW-1:0]  data_i = '0;
    logic                valid_i = 1'b0;
    logic                init_i = 1'b0;
    logic                last_i = 1'b0;
    logic [DEPW-1:0]     valid_depth_i = '0;
    logic                sat_en_i = 1'b0;
    logic [SIZE*AW-1:0]  data_o;
    logic                out_valid_o;
    logic [SIZE-1:0]     ovf_o;
    logic                tile_done_o;

    skew_acc_array #(.SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .DEPTH_W(DEPW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .init_i       (init_i),
        .last_i       (last_i),
        .valid_depth_i(valid_depth_i),
        .sat_en_i     (sat_en_i),
        .data_o       (data_o),
        .out_valid_o  (out_valid_o),
        .ovf_o        (ovf_o),
        .tile_done_o  (tile_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic            s_v [8];
    logic            s_i [8];
    logic            s_l [8];
    logic [DEPW-1:0] s_d [8];
    logic [31:0]     s_x [8];

    int          nb;
    int          nd;
    int          d_cyc;
    int          b_cyc [4];
    logic [31:0] b_dat [4];
    logic [3:0]  b_ovf [4];

    task automatic set_tok(input int k, input logic v, input logic i, input logic l, input logic [DEPW-1:0] d, input logic [31:0] x);
        s_v[k] = v; s_i[k] = i; s_l[k] = l; s_d[k] = d; s_x[k] = x;
    endtask

    // Token k enters at edge k; lane l sees token k's data at edge k+l
    task automatic drive(input int n, input int cyc);
        nb = 0;
        nd = 0;
        d_cyc = -1;
        for (int t = 0; t < cyc; t++) begin
            @(negedge clk);
            valid_i       = (t < n) ? s_v[t] : 1'b0;
            init_i        = (t < n) ? s_i[t] : 1'b0;
            last_i        = (t < n) ? s_l[t] : 1'b0;
            valid_depth_i = (t < n) ? s_d[t] : '0;
            for (int l = 0; l < SIZE; l++) begin
                logic [31:0] w;
                w = (t - l >= 0 && t - l < n) ? s_x[t-l] : 32'h0;
                data_i[l*DW +: DW] = w[l*DW +: DW];
            end
            @(posedge clk);
            #1;
            if (out_valid_o) begin
                if (nb < 4) begin b_cyc[nb] = t; b_dat[nb] = data_o; b_ovf[nb] = ovf_o; end
                nb++;
            end
            if (tile_done_o) begin d_cyc = t; nd++; end
        end
        @(negedge clk);
        valid_i = 1'b0; init_i = 1'b0; last_i = 1'b0; valid_depth_i = '0; data_i = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", data_o, 32'h0);
        check("rst_valid", {31'b0, out_valid_o}, 32'h0);
        check("rst_ovf", {28'b0, ovf_o}, 32'h0);
        check("rst_done", {31'b0, tile_done_o}, 32'h0);
        rst_n = 1'b1;

        set_tok(0, 1, 1, 0, 3'd4, 32'h04030201);
        set_tok(1, 1, 0, 1, 3'd4, 32'h281e140a);
        drive(2, 9);
        check("t1_nbeats", nb, 1);
        check("t1_cycle", b_cyc[0], 5);
        check("t1_data", b_dat[0], 32'h2c21160b);
        check("t1_ovf", {28'b0, b_ovf[0]}, 32'h0);
        check("t1_ndone", nd, 1);
        check("t1_done_cyc", d_cyc, 6);

        set_tok(0, 1, 1, 0, 3'd2, 32'h04030201);
        set_tok(1, 1, 0, 1, 3'd2, 32'h281e140a);
        drive(2, 9);
        check("d2_nbeats", nb, 1);
        check("d2_data", b_dat[0], 32'h0000160b);

        sat_en_i = 1'b1;
        set_tok(0, 1, 1, 0, 3'd1, 32'h00000064);
        set_tok(1, 1, 0, 1, 3'd1, 32'h00000064);
        drive(2, 9);
        check("sat_nbeats", nb, 1);
        check("sat_data", b_dat[0], 32'h0000007f);
        check("sat_ovf", {28'b0, b_ovf[0]}, 32'h1);

        sat_en_i = 1'b0;
        drive(2, 9);
        check("wrap_data", b_dat[0], 32'h000000c8);
        check("wrap_ovf", {28'b0, b_ovf[0]}, 32'h1);

        set_tok(0, 1, 1, 1, 3'd4, 32'h05050505);
        set_tok(1, 1, 1, 1, 3'd4, 32'h06060606);
        set_tok(2, 1, 1, 1, 3'd4, 32'h07070707);
        drive(3, 10);
        check("b2b_nbeats", nb, 3);
        check("b2b_first_cyc", b_cyc[0], 4);
        check("b2b_last_cyc", b_cyc[2], 6);
        check("b2b_data0", b_dat[0], 32'h05050505);
        check("b2b_data1", b_dat[1], 32'h06060606);
        check("b2b_data2", b_dat[2], 32'h07070707);
        check("b2b_ndone", nd, 1);
        check("b2b_done_cyc", d_cyc, 7);

        set_tok(0, 1, 1, 0, 3'd4, 32'h04030201);
        set_tok(1, 0, 1, 1, 3'd4, 32'h63636363);
        set_tok(2, 0, 0, 1, 3'd4, 32'h63636363);
        set_tok(3, 1, 0, 1, 3'd4, 32'h281e140a);
        drive(4, 11);
        check("bub_nbeats", nb, 1);
        check("bub_cycle", b_cyc[0], 7);
        check("bub_data", b_dat[0], 32'h2c21160b);

        set_tok(0, 1, 1, 0, 3'd4, 32'h04030201);
        set_tok(1, 1, 0, 1, 3'd4, 32'h281e140a);
        drive(2, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 8);
        check("midrst_nbeats", nb, 0);
        drive(2, 9);
        check("fresh_nbeats", nb, 1);
        check("fresh_data", b_dat[0], 32'h2c21160b);
        check("fresh_ovf", {28'b0, b_ovf[0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
